vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates raster timing for the Pong display: horizontal/vertical counters, HSYNC/VSYNC, active-area flag and current pixel coordinates.
- Sits directly upstream of the bar and ball renderers. They consume o_active, o_x and o_y.
- Also supplies a vertical-blank strobe, so sprite coordinate updates commit between frames and no longer depend on free-running delay counters.
- Defaults target 800x600@72 Hz with a 50 MHz clk_in (1 pixel per clock).

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (clocks)
H_SYNC, 120, horizontal sync width (clocks)
H_BP, 64, horizontal back porch (clocks)
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, HSYNC asserted level
VS_POL, 1, VSYNC asserted level

Ports:
clk_in  input  1  base clock, 50 MHz from board
i_rst_n  input  1  asynchronous active-low reset
o_hs  output  1  horizontal sync
o_vs  output  1  vertical sync
o_active  output  1  high while the current pixel is in the visible area
o_x  output  11  current horizontal counter value
o_y  output  10  current vertical counter value
o_frame_start  output  1  one-clock pulse on the first pixel of a frame (x=0, y=0)
o_vblank_start  output  1  one-clock pulse on the first clock of line V_ACTIVE (x=0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 666).
- Counter widths: h_cnt 11 bits, v_cnt 10 bits. H_TOTAL must be ≤ 2048 and V_TOTAL ≤ 1024; violations are a configuration error, flagged by elaboration-time check.
- Reset (i_rst_n low, asynchronous): h_cnt=0, v_cnt=0, o_x=0, o_y=0, o_active=0, o_hs=!HS_POL, o_vs=!VS_POL, o_frame_start=0, o_vblank_start=0.
- Counting:
  - h_cnt increments every clk_in. At H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt wraps from V_TOTAL-1 to 0 when h_cnt wraps.
  - Simultaneous h and v wrap: both go to 0 in the same cycle.
- Decode from (h_cnt, v_cnt), registered once; all outputs have exactly 1-clock latency and are mutually aligned:
  - o_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - o_hs = HS_POL when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, else !HS_POL
  - o_vs = VS_POL when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, else !VS_POL (line-granular; changes at h_cnt=0)
  - o_x = h_cnt, o_y = v_cnt, reported in blanking too. Consumers must gate with o_active.
  - o_frame_start = (h_cnt==0 && v_cnt==0)
  - o_vblank_start = (h_cnt==0 && v_cnt==V_ACTIVE)
- First cycle after reset release: counters are at (0,0). o_frame_start is asserted one clock later, so a frame always begins cleanly after reset.
- Reset mid-frame: outputs return to reset values immediately. The raster restarts at (0,0) with no partial-line artefacts carried over.
- No handshake. Outputs are free-running and must never stall.

Optional Feature:
VGA_FRAME_CNT_EN
- Defined: adds output o_frame_cnt [15:0]. It resets to 0, increments in the same cycle o_frame_start is asserted, and wraps 0xFFFF→0. Renderers use it for frame-rate animation timing.
- Undefined: port and counter absent. All other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants (H_/V_ active, porch and sync values for 800x600@72)
  - derived H_TOTAL/V_TOTAL
  - coordinate widths (X_W=11, Y_W=10)
- Renderers (bar, ball) import the same widths.
- One natural sub-module: vga_axis_counter. It is a parameterised wrap counter with a terminal-count output, instantiated twice (horizontal, and vertical enabled by the horizontal terminal count).

Test Plan:
- Reset then release; run 2 frames -> o_frame_start pulses exactly 692640 clocks apart; first pulse 1 clock after the first post-release edge.
- Line check -> o_hs at HS_POL for exactly 120 clocks per line, starting when o_x=856; o_active high for exactly 800 clocks per line at o_x 0..799.
- Frame check -> o_vs at VS_POL for exactly 6 lines starting at o_y=637; o_active never high while o_y ≥ 600; o_vblank_start pulses once per frame with o_x=0, o_y=600.
- Wrap -> after o_x=1039, o_y=665 the next cycle shows o_x=0, o_y=0, o_frame_start=1.
- Assert i_rst_n low mid-line at o_x=400, o_y=300 -> all outputs at reset values asynchronously; after release, the raster restarts at (0,0).
- With VGA_FRAME_CNT_EN -> o_frame_cnt reads 3 after the 3rd o_frame_start; force to 0xFFFF via 65535 frames (or a backdoor) -> next frame reads 0.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared raster constants for the Pong display path: default timing for
// 800x600@72 Hz at 50 MHz (one pixel per clock), derived line/frame totals
// and the coordinate widths that the bar and ball renderers also import.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_pkg;

    // Coordinate widths shared with the renderers.
    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    // Default horizontal timing, in clocks.
    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 56;
    localparam int unsigned DEF_H_SYNC   = 120;
    localparam int unsigned DEF_H_BP     = 64;

    // Default vertical timing, in lines.
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 37;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BP     = 23;

    // Length of one axis: visible + front porch + sync + back porch.
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL =
        axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);   // 1040
    localparam int unsigned DEF_V_TOTAL =
        axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);   // 666

endpackage : vga_pkg

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// Wrap counter for one raster axis. Counts 0..TOTAL-1 while en is high and
// wraps to 0. tc flags the enabled clock on which the wrap happens, so the
// horizontal instance's tc is the advance enable of the vertical instance.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (cnt -> 0)
//   en     in   count enable
//   cnt    out  current count [W-1:0]
//   tc     out  terminal count: en && cnt == TOTAL-1 (combinational)
// ---------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int unsigned W     = 11,
    parameter int unsigned TOTAL = 1040
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule : vga_axis_counter

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Free-running raster timing for the Pong display. A horizontal and a
// vertical wrap counter walk the raster; the decode of (h_cnt, v_cnt) is
// registered once so every output carries exactly one clock of latency and
// all outputs stay mutually aligned. There is no handshake: outputs update
// every clock and never stall; consumers gate o_x/o_y with o_active.
// Optional build macro: VGA_FRAME_CNT_EN adds the 16-bit frame counter.
// Ports:
//   clk_in          in   pixel clock (50 MHz default)
//   i_rst_n         in   asynchronous active-low reset
//   o_hs            out  horizontal sync, asserted level HS_POL
//   o_vs            out  vertical sync, asserted level VS_POL (line granular)
//   o_active        out  current pixel lies in the visible area
//   o_x             out  horizontal count [10:0], also valid in blanking
//   o_y             out  vertical count [9:0], also valid in blanking
//   o_frame_start   out  one-clock pulse at (0,0)
//   o_vblank_start  out  one-clock pulse at (0,V_ACTIVE)
//   o_frame_cnt     out  frames started, wraps 0xFFFF->0 (VGA_FRAME_CNT_EN)
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic           clk_in,
    input  logic           i_rst_n,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_active,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_frame_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0]    o_frame_cnt,
`endif
    output logic           o_vblank_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Sync windows, as half-open ranges [START, END) on each axis.
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // The counters cannot represent a longer raster.
    if (H_TOTAL > (1 << X_W)) begin : g_h_total_too_big
        $error("vga_timing_gen: H_TOTAL exceeds the 11-bit horizontal counter");
    end
    if (V_TOTAL > (1 << Y_W)) begin : g_v_total_too_big
        $error("vga_timing_gen: V_TOTAL exceeds the 10-bit vertical counter");
    end

    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic           h_tc;
    logic           v_tc;

    vga_axis_counter #(.W(X_W), .TOTAL(H_TOTAL)) u_h_cnt (
        .clk   (clk_in),
        .rst_n (i_rst_n),
        .en    (1'b1),
        .cnt   (h_cnt),
        .tc    (h_tc)
    );

    // The vertical axis advances only on the clock the line wraps, so a
    // simultaneous h/v wrap lands both counters on 0 in the same cycle.
    vga_axis_counter #(.W(Y_W), .TOTAL(V_TOTAL)) u_v_cnt (
        .clk   (clk_in),
        .rst_n (i_rst_n),
        .en    (h_tc),
        .cnt   (v_cnt),
        .tc    (v_tc)
    );

    // The end of frame is visible from the counters directly; nothing
    // downstream needs the vertical terminal count.
    logic unused_v_tc;
    assign unused_v_tc = v_tc;

    // Decode of the current raster position, compared in 32 bits so a sync
    // window that ends exactly at the counter range is still well formed.
    logic in_active;
    logic in_hs;
    logic in_vs;
    logic at_origin;
    logic at_vblank;

    assign in_active = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign in_hs     = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    assign in_vs     = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign at_vblank = (h_cnt == '0) && (32'(v_cnt) == V_ACTIVE);

    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x            <= '0;
            o_y            <= '0;
            o_active       <= 1'b0;
            o_hs           <= !HS_POL;
            o_vs           <= !VS_POL;
            o_frame_start  <= 1'b0;
            o_vblank_start <= 1'b0;
        end else begin
            o_x            <= h_cnt;
            o_y            <= v_cnt;
            o_active       <= in_active;
            o_hs           <= in_hs ? HS_POL : !HS_POL;
            o_vs           <= in_vs ? VS_POL : !VS_POL;
            o_frame_start  <= at_origin;
            o_vblank_start <= at_vblank;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Advances on the same edge that raises o_frame_start, so the count
    // already includes the frame that is just beginning.
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= '0;
        end else if (at_origin) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share clock and reset: dut_s uses a shrunken raster
// (31 x 17, VSYNC active-low) so whole frames fit in a short run, dut_d
// uses the default 800x600@72 timing and is checked over its first lines.
// The reference model derives the raster position from the number of clock
// edges since reset release with plain division/modulo.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hsy, hbp;
        int va, vfp, vsy, vbp;
        bit hp, vp;
    } timing_t;

    typedef struct packed {
        logic        active;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        vb;
        logic [10:0] x;
        logic [9:0]  y;
    } outs_t;

    typedef struct {
        int    k;
        outs_t e;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT wiring ----------------
    logic        s_hs, s_vs, s_active, s_fs, s_vb;
    logic [10:0] s_x;
    logic [9:0]  s_y;
    logic        d_hs, d_vs, d_active, d_fs, d_vb;
    logic [10:0] d_x;
    logic [9:0]  d_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] s_fc, d_fc;
`endif

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut_s (
        .clk_in         (clk),
        .i_rst_n        (rst_n),
        .o_hs           (s_hs),
        .o_vs           (s_vs),
        .o_active       (s_active),
        .o_x            (s_x),
        .o_y            (s_y),
        .o_frame_start  (s_fs),
`ifdef VGA_FRAME_CNT_EN
        .o_frame_cnt    (s_fc),
`endif
        .o_vblank_start (s_vb)
    );

    vga_timing_gen dut_d (
        .clk_in         (clk),
        .i_rst_n        (rst_n),
        .o_hs           (d_hs),
        .o_vs           (d_vs),
        .o_active       (d_active),
        .o_x            (d_x),
        .o_y            (d_y),
        .o_frame_start  (d_fs),
`ifdef VGA_FRAME_CNT_EN
        .o_frame_cnt    (d_fc),
`endif
        .o_vblank_start (d_vb)
    );

    // ---------------- scoreboard state ----------------
    int      n_checks = 0;
    int      n_fail   = 0;
    int      k        = 0;     // posedges since reset release
    timing_t ts, td;
    bit      fc_model_en = 1'b1;

    // statistics gathered during the first clean run
    bit stats_en = 1'b0;
    int d_hs_cnt = 0, d_hs_first_x = -1, d_act_cnt = 0, d_act_min = 9999, d_act_max = -1;
    int s_vs_lines = 0, s_vs_first_y = -1, s_act_blank = 0;
    int s_vb_cnt = 0, s_vb_badpos = 0;
    int s_fs_last = -1, s_fs_badgap = 0, s_fs_first = -1;

    // ---------------- reference model ----------------
    function automatic outs_t model(timing_t tm, int kk);
        outs_t o;
        int ht, vt, c, x, y;
        ht = tm.ha + tm.hfp + tm.hsy + tm.hbp;
        vt = tm.va + tm.vfp + tm.vsy + tm.vbp;
        o = '0;
        o.hs = !tm.hp;
        o.vs = !tm.vp;
        if (kk > 0) begin
            c = kk - 1;
            x = c % ht;
            y = (c / ht) % vt;
            o.x      = 11'(x);
            o.y      = 10'(y);
            o.active = (x < tm.ha) && (y < tm.va);
            o.hs     = ((x >= tm.ha + tm.hfp) && (x < tm.ha + tm.hfp + tm.hsy)) ? tm.hp : !tm.hp;
            o.vs     = ((y >= tm.va + tm.vfp) && (y < tm.va + tm.vfp + tm.vsy)) ? tm.vp : !tm.vp;
            o.fs     = (x == 0) && (y == 0);
            o.vb     = (x == 0) && (y == tm.va);
        end
        return o;
    endfunction

    function automatic int model_fc(timing_t tm, int kk);
        int fl;
        fl = (tm.ha + tm.hfp + tm.hsy + tm.hbp) * (tm.va + tm.vfp + tm.vsy + tm.vbp);
        if (kk == 0) return 0;
        return ((kk - 1) / fl + 1) % 65536;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk_outs(string name, outs_t g, outs_t e);
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s k=%0d got act=%b hs=%b vs=%b fs=%b vb=%b x=%0d y=%0d required act=%b hs=%b vs=%b fs=%b vb=%b x=%0d y=%0d",
                     name, k, g.active, g.hs, g.vs, g.fs, g.vb, g.x, g.y,
                     e.active, e.hs, e.vs, e.fs, e.vb, e.x, e.y);
        end
    endtask

    task automatic chk(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got %0d required %0d", name, k, got, exp);
        end
    endtask

    function automatic outs_t got_s();
        outs_t g;
        g = '{s_active, s_hs, s_vs, s_fs, s_vb, s_x, s_y};
        return g;
    endfunction

    function automatic outs_t got_d();
        outs_t g;
        g = '{d_active, d_hs, d_vs, d_fs, d_vb, d_x, d_y};
        return g;
    endfunction

    task automatic check_all();
        chk_outs("small_raster", got_s(), model(ts, k));
        chk_outs("default_raster", got_d(), model(td, k));
`ifdef VGA_FRAME_CNT_EN
        if (fc_model_en) begin
            chk("small_frame_cnt", int'(s_fc), model_fc(ts, k));
            chk("default_frame_cnt", int'(d_fc), model_fc(td, k));
        end
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic collect_stats();
        if (k >= 1 && k <= 1040) begin
            if (d_hs == 1'b1) begin
                d_hs_cnt++;
                if (d_hs_first_x < 0) d_hs_first_x = int'(d_x);
            end
            if (d_active) begin
                d_act_cnt++;
                if (int'(d_x) < d_act_min) d_act_min = int'(d_x);
                if (int'(d_x) > d_act_max) d_act_max = int'(d_x);
            end
        end
        if (k >= 1 && k <= 1054) begin
            if (s_x == 11'd0 && s_vs == 1'b0) begin
                s_vs_lines++;
                if (s_vs_first_y < 0) s_vs_first_y = int'(s_y);
            end
            if (s_vb) begin
                s_vb_cnt++;
                if (s_x != 11'd0 || s_y != 10'd10) s_vb_badpos++;
            end
        end
        if (s_active && s_y >= 10'd10) s_act_blank++;
        if (s_fs) begin
            if (s_fs_first < 0) s_fs_first = k;
            if (s_fs_last >= 0 && (k - s_fs_last) != 527) s_fs_badgap++;
            s_fs_last = k;
        end
    endtask

    // One clock: let the active edge pass, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
        check_all();
        if (stats_en) collect_stats();
    endtask

    // Async assertion between edges, hold, release on a falling edge.
    task automatic pulse_reset(int hold);
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        k = 0;
        check_all();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_all();
        end
        rst_n = 1'b1;
        k = 0;
        check_all();
    endtask

    // ---------------- test body ----------------
    vec_t vecs[14];

    initial begin
        ts = '{16, 4, 6, 5, 10, 2, 3, 2, 1'b1, 1'b0};
        td = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};

        //            k     act hs vs fs vb  x   y
        vecs[0]  = '{  0, '{0, 0, 1, 0, 0,  0,  0}};
        vecs[1]  = '{  1, '{1, 0, 1, 1, 0,  0,  0}};
        vecs[2]  = '{ 16, '{1, 0, 1, 0, 0, 15,  0}};
        vecs[3]  = '{ 17, '{0, 0, 1, 0, 0, 16,  0}};
        vecs[4]  = '{ 21, '{0, 1, 1, 0, 0, 20,  0}};
        vecs[5]  = '{ 26, '{0, 1, 1, 0, 0, 25,  0}};
        vecs[6]  = '{ 27, '{0, 0, 1, 0, 0, 26,  0}};
        vecs[7]  = '{ 32, '{1, 0, 1, 0, 0,  0,  1}};
        vecs[8]  = '{311, '{0, 0, 1, 0, 1,  0, 10}};
        vecs[9]  = '{373, '{0, 0, 0, 0, 0,  0, 12}};
        vecs[10] = '{465, '{0, 0, 0, 0, 0, 30, 14}};
        vecs[11] = '{466, '{0, 0, 1, 0, 0,  0, 15}};
        vecs[12] = '{527, '{0, 0, 1, 0, 0, 30, 16}};
        vecs[13] = '{528, '{1, 0, 1, 1, 0,  0,  0}};

        // Reset held low: reset values on both instances.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        k = 0;
        check_all();
        rst_n = 1'b1;

        // Clean run from release: table vectors, then through >4 small frames
        // and the first two default lines.
        stats_en = 1'b1;
        check_all();
        for (int i = 0; i < 14; i++) begin
            while (k < vecs[i].k) step();
            chk_outs($sformatf("vector_k%0d", vecs[i].k), got_s(), vecs[i].e);
        end
        while (k < 2200) step();
        stats_en = 1'b0;

        chk("d_hs_width", d_hs_cnt, 120);
        chk("d_hs_start_x", d_hs_first_x, 856);
        chk("d_active_width", d_act_cnt, 800);
        chk("d_active_min_x", d_act_min, 0);
        chk("d_active_max_x", d_act_max, 799);
        chk("s_vs_lines_2frames", s_vs_lines, 6);
        chk("s_vs_start_y", s_vs_first_y, 12);
        chk("s_active_in_vblank", s_act_blank, 0);
        chk("s_vblank_pulses_2frames", s_vb_cnt, 2);
        chk("s_vblank_position", s_vb_badpos, 0);
        chk("s_first_frame_start_k", s_fs_first, 1);
        chk("s_frame_start_gap", s_fs_badgap, 0);

        // Mid-line reset at (8,5), then clean restart at (0,0).
        for (int i = 0; i < 600 && !(s_x == 11'd8 && s_y == 10'd5); i++) step();
        chk("reach_x8_y5", int'(s_x == 11'd8 && s_y == 10'd5), 1);
        pulse_reset(2);
        step();
        chk("restart_x", int'(s_x), 0);
        chk("restart_y", int'(s_y), 0);
        chk("restart_frame_start", int'(s_fs), 1);
        repeat (300) step();

        // Randomised run lengths and reset points.
        repeat (4) begin
            int n;
            n = $urandom_range(5, 1200);
            repeat (n) step();
            pulse_reset($urandom_range(1, 3));
            repeat ($urandom_range(1, 40)) step();
        end

`ifdef VGA_FRAME_CNT_EN
        // Backdoor the counter to 0xFFFF; the next frame start wraps it to 0.
        fc_model_en = 1'b0;
        step();
        force dut_s.frame_cnt_q = 16'hFFFF;
        #1;
        release dut_s.frame_cnt_q;
        chk("fc_forced", int'(s_fc), 65535);
        for (int i = 0; i < 600 && !s_fs; i++) step();
        chk("fc_wrap_fs_seen", int'(s_fs), 1);
        chk("fc_wrap_zero", int'(s_fc), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vga_timing_gen
